// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage for an 8-bit core. Issues byte-wide instruction requests at the
// fetch PC, registers the returned instruction for the decoder and hands it
// over with a valid/ready handshake. A taken branch (redirect) flushes any
// in-flight or held instruction and restarts fetch at redirect_pc.
//
// Optional feature (macro FETCH_PREFETCH_EN): adds a one-entry prefetch
// buffer so the next instruction is fetched while the current one waits in
// HOLD. This gives one instruction per cycle with zero-wait memory.
// With the macro undefined the block delivers one instruction per two cycles.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_req/addr   request to instruction memory (addr = fetch PC)
//   imem_ack/rdata  memory response; ignored while imem_req=0
//   instr, instr_pc registered instruction and its fetch address
//   instr_valid     instr/instr_pc hold a live instruction
//   instr_ready     decoder accepts instr (transfer = valid & ready)
//   redirect/_pc    flush and refetch from redirect_pc (highest priority)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_rdata,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       redirect,
    input  logic [7:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t     state;
    logic [7:0] fetch_pc;
    logic       ack;
    logic       xfer;

`ifdef FETCH_PREFETCH_EN
    logic [7:0] pf_data;
    logic [7:0] pf_pc;
    logic       pf_full;

    // In HOLD the next instruction is fetched early unless the buffer already
    // holds it.
    assign imem_req = (state == FETCH) || ((state == HOLD) && !pf_full);
`else
    assign imem_req = (state == FETCH);
`endif

    assign imem_addr = fetch_pc;
    assign ack       = imem_ack && imem_req;
    assign xfer      = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            instr       <= 8'h00;
            instr_pc    <= 8'h00;
            instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_data     <= 8'h00;
            pf_pc       <= 8'h00;
            pf_full     <= 1'b0;
`endif
        end else if (redirect) begin
            // Redirect beats ack and transfer; same-cycle rdata is dropped.
            state       <= FETCH;
            fetch_pc    <= redirect_pc;
            instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pf_full     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= FETCH;

                FETCH: begin
                    if (ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= fetch_pc;
                        fetch_pc    <= fetch_pc + 8'd1;  // wraps FF -> 00
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end

                HOLD: begin
`ifdef FETCH_PREFETCH_EN
                    if (xfer) begin
                        if (pf_full) begin
                            instr    <= pf_data;
                            instr_pc <= pf_pc;
                            pf_full  <= 1'b0;
                        end else if (ack) begin
                            // Bypass the empty buffer straight into instr.
                            instr    <= imem_rdata;
                            instr_pc <= fetch_pc;
                            fetch_pc <= fetch_pc + 8'd1;
                        end else begin
                            // Request stays up: FETCH keeps imem_req high.
                            instr_valid <= 1'b0;
                            state       <= FETCH;
                        end
                    end else if (ack) begin
                        pf_data  <= imem_rdata;
                        pf_pc    <= fetch_pc;
                        pf_full  <= 1'b1;
                        fetch_pc <= fetch_pc + 8'd1;
                    end
`else
                    if (xfer) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch in its default build (no prefetch buffer).
// Inputs change 1 ns after each rising edge; outputs are checked at the same
// point, i.e. they reflect the state loaded by the preceding edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(.RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        #1;
        chk("rst_req",   {7'b0, imem_req},    8'h00);
        chk("rst_valid", {7'b0, instr_valid}, 8'h00);
        chk("rst_instr", instr,               8'h00);
        chk("rst_ipc",   instr_pc,            8'h00);
        chk("rst_addr",  imem_addr,           8'h00);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("idle_req", {7'b0, imem_req}, 8'h00);
        tick();
        chk("fetch_req",  {7'b0, imem_req}, 8'h01);
        chk("fetch_addr", imem_addr,        8'h00);

        // Delayed ack: request held at constant address for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req",   {7'b0, imem_req},    8'h01);
            chk("wait_addr",  imem_addr,           8'h00);
            chk("wait_valid", {7'b0, instr_valid}, 8'h00);
        end
        imem_ack = 1'b1; imem_rdata = 8'h5A;
        tick();
        imem_ack = 1'b0;
        chk("ld_valid", {7'b0, instr_valid}, 8'h01);
        chk("ld_instr", instr,               8'h5A);
        chk("ld_ipc",   instr_pc,            8'h00);
        chk("ld_addr",  imem_addr,           8'h01);

        // Stall: downstream not ready for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_instr", instr,               8'h5A);
            chk("stall_ipc",   instr_pc,            8'h00);
            chk("stall_valid", {7'b0, instr_valid}, 8'h01);
            chk("stall_req",   {7'b0, imem_req},    8'h00);
        end
        instr_ready = 1'b1;
        tick();
        chk("xfer_valid", {7'b0, instr_valid}, 8'h00);
        chk("xfer_req",   {7'b0, imem_req},    8'h01);
        chk("xfer_addr",  imem_addr,           8'h01);

        // Zero-wait stream: valid every other cycle, addresses 01,02,03.
        imem_ack = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            imem_rdata = 8'h10 + 8'(i);
            tick();
            chk("str_valid", {7'b0, instr_valid}, 8'h01);
            chk("str_instr", instr,               8'h10 + 8'(i));
            chk("str_ipc",   instr_pc,            8'(i));
            chk("str_req",   {7'b0, imem_req},    8'h00);
            tick();
            chk("str_gap",   {7'b0, instr_valid}, 8'h00);
            chk("str_addr",  imem_addr,           8'(i + 1));
        end

        // Redirect in the same cycle as an ack: C3 must be dropped.
        redirect = 1'b1; redirect_pc = 8'h40; imem_rdata = 8'hC3;
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        chk("rd_valid", {7'b0, instr_valid}, 8'h00);
        chk("rd_addr",  imem_addr,           8'h40);
        chk("rd_req",   {7'b0, imem_req},    8'h01);
        tick();
        chk("rd_valid2", {7'b0, instr_valid}, 8'h00);
        chk("rd_addr2",  imem_addr,           8'h40);
        imem_ack = 1'b1; imem_rdata = 8'h99;
        tick();
        chk("rd_instr", instr,               8'h99);
        chk("rd_ipc",   instr_pc,            8'h40);
        chk("rd_v",     {7'b0, instr_valid}, 8'h01);

        // Redirect from HOLD to FE, then wrap FE -> FF -> 00.
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        chk("wr_valid", {7'b0, instr_valid}, 8'h00);
        chk("wr_addr0", imem_addr,           8'hFE);
        imem_ack = 1'b1; imem_rdata = 8'hA0;
        tick();
        chk("wr_ipc0", instr_pc, 8'hFE);
        tick();
        chk("wr_addr1", imem_addr, 8'hFF);
        imem_rdata = 8'hA1;
        tick();
        chk("wr_ipc1",   instr_pc, 8'hFF);
        chk("wr_instr1", instr,    8'hA1);
        tick();
        chk("wr_addr2", imem_addr, 8'h00);
        imem_rdata = 8'hA2;
        tick();
        chk("wr_ipc2", instr_pc, 8'h00);
        tick();
        chk("wr_addr3", imem_addr, 8'h01);

        // Reset while a request is outstanding with no ack.
        imem_ack = 1'b0;
        tick();
        chk("pre_rst_req", {7'b0, imem_req}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   {7'b0, imem_req},    8'h00);
        chk("mid_rst_instr", instr,               8'h00);
        chk("mid_rst_ipc",   instr_pc,            8'h00);
        chk("mid_rst_addr",  imem_addr,           8'h00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", {7'b0, imem_req}, 8'h00);
        tick();
        chk("post_rst_req",  {7'b0, imem_req}, 8'h01);
        chk("post_rst_addr", imem_addr,        8'h00);

        // Redirect while in IDLE.
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1; redirect = 1'b1; redirect_pc = 8'h20;
        tick();
        redirect = 1'b0;
        chk("idle_rd_req",  {7'b0, imem_req}, 8'h01);
        chk("idle_rd_addr", imem_addr,        8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
